// File: rtl/seg_scan_controller_if.sv
// Segment-bus scan interface: pattern inputs and the scanned seg/sel outputs.
// Optional brightness input exists only when SEG_SCAN_DIM_EN is defined.
interface seg_scan_controller_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    enable;
  logic [7*NUM_DIGITS-1:0] digit_seg;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]              brightness;
`endif
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    frame_start;
  logic                    busy;

  // master: the scan controller, which drives the shared segment bus
  modport master (
    input  enable,
    input  digit_seg,
`ifdef SEG_SCAN_DIM_EN
    input  brightness,
`endif
    output seg_out,
    output sel,
    output frame_start,
    output busy
  );

  // slave: pattern source / pin side of the bus
  modport slave (
    output enable,
    output digit_seg,
`ifdef SEG_SCAN_DIM_EN
    output brightness,
`endif
    input  seg_out,
    input  sel,
    input  frame_start,
    input  busy
  );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-division 7-segment scanner: one-hot digit selects, blanking gap, frame snapshot.
// Optional PWM dimming is built when SEG_SCAN_DIM_EN is defined.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  seg_scan_controller_if.master bus
);

  localparam int unsigned DIGIT_W = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam bit          HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [6:0]         SEG_DARK   = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } state_t;

  state_t                  r_state,     w_state_next;
  logic [DIGIT_W-1:0]      r_digit,     w_digit_next;
  logic [DWELL_W-1:0]      r_dwell_cnt, w_dwell_next;
  logic [BLANK_W-1:0]      r_blank_cnt, w_blank_next;
  logic [7*NUM_DIGITS-1:0] r_snap,      w_snap_next;
  logic [6:0]              r_seg,       w_seg_next;
  logic [NUM_DIGITS-1:0]   r_sel,       w_sel_next;
  logic                    r_frame_start;
  logic                    r_busy;
  logic                    w_take;
  logic                    w_drive_entry;
  logic                    w_lit;
  logic [6:0]              w_pattern;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]              r_pwm, w_pwm_next;
`endif

  // Next-state / counter logic
  always_comb begin
    w_state_next  = r_state;
    w_digit_next  = r_digit;
    w_dwell_next  = r_dwell_cnt;
    w_blank_next  = r_blank_cnt;
    w_take        = 1'b0;
    w_drive_entry = 1'b0;

    if (!bus.enable) begin
      w_state_next = ST_IDLE;
      w_digit_next = '0;
      w_dwell_next = '0;
      w_blank_next = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_take       = 1'b1;
          w_digit_next = '0;
          w_dwell_next = '0;
          w_blank_next = '0;
          if (HAS_BLANK) begin
            w_state_next = ST_BLANK;
          end else begin
            w_state_next  = ST_DRIVE;
            w_drive_entry = 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_blank_cnt == BLANK_LAST) begin
            w_blank_next  = '0;
            w_state_next  = ST_DRIVE;
            w_drive_entry = 1'b1;
          end else begin
            w_blank_next = r_blank_cnt + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (r_dwell_cnt == DWELL_LAST) begin
            w_dwell_next = '0;
            // wrapping past the last digit starts a new frame with a fresh snapshot
            if (r_digit == DIGIT_LAST) begin
              w_digit_next = '0;
              w_take       = 1'b1;
            end else begin
              w_digit_next = r_digit + 1'b1;
            end
            if (HAS_BLANK) begin
              w_state_next = ST_BLANK;
            end else begin
              w_state_next  = ST_DRIVE;
              w_drive_entry = 1'b1;
            end
          end else begin
            w_dwell_next = r_dwell_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_digit_next = '0;
          w_dwell_next = '0;
          w_blank_next = '0;
        end
      endcase
    end
  end

  // Outputs are registered, so they are computed from the state being entered
  always_comb begin
    w_snap_next = w_take ? bus.digit_seg : r_snap;
    w_pattern   = w_snap_next[7*w_digit_next +: 7];
`ifdef SEG_SCAN_DIM_EN
    w_pwm_next = '0;
    if (w_state_next == ST_DRIVE) begin
      w_pwm_next = w_drive_entry ? 4'd0 : r_pwm + 4'd1;
    end
    w_lit = (w_pwm_next <= bus.brightness);
`else
    w_lit = 1'b1;
`endif
    w_seg_next = SEG_DARK;
    w_sel_next = '0;
    if (w_state_next == ST_DRIVE) begin
      w_sel_next = NUM_DIGITS'(1) << w_digit_next;
      w_seg_next = w_lit ? w_pattern : SEG_DARK;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_digit       <= '0;
      r_dwell_cnt   <= '0;
      r_blank_cnt   <= '0;
      r_snap        <= '1;
      r_seg         <= SEG_DARK;
      r_sel         <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_digit       <= w_digit_next;
      r_dwell_cnt   <= w_dwell_next;
      r_blank_cnt   <= w_blank_next;
      r_snap        <= w_snap_next;
      r_seg         <= w_seg_next;
      r_sel         <= w_sel_next;
      r_frame_start <= w_take;
      r_busy        <= (w_state_next != ST_IDLE);
    end
  end

`ifdef SEG_SCAN_DIM_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_pwm_next;
    end
  end
`endif

  assign bus.seg_out     = r_seg;
  assign bus.sel         = r_sel;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller: 4-digit scanner plus a 1-digit long-dwell instance.
// With SEG_SCAN_DIM_EN defined the 1-digit instance also exercises PWM dimming.
module tb_seg_scan_controller;

  localparam logic [27:0] P1 = {7'h40, 7'h79, 7'h24, 7'h30};
  localparam logic [27:0] P2 = {7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [6:0]  PONE = 7'h19;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  seg_scan_controller_if #(.NUM_DIGITS(4)) m_if ();
  seg_scan_controller_if #(.NUM_DIGITS(1)) o_if ();

  seg_scan_controller #(
    .NUM_DIGITS  (4),
    .DWELL_CYCLES(4),
    .BLANK_CYCLES(2)
  ) u_dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (m_if)
  );

  seg_scan_controller #(
    .NUM_DIGITS  (1),
    .DWELL_CYCLES(32),
    .BLANK_CYCLES(2)
  ) u_one (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (o_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [3:0] sel, input logic [6:0] seg,
                          input logic fs, input logic busy);
    chk({tag, ".sel"},  32'(m_if.sel),         32'(sel));
    chk({tag, ".seg"},  32'(m_if.seg_out),     32'(seg));
    chk({tag, ".fs"},   32'(m_if.frame_start), 32'(fs));
    chk({tag, ".busy"}, 32'(m_if.busy),        32'(busy));
  endtask

  task automatic main_blank(input string tag, input logic fs);
    tick();
    chk_main(tag, 4'b0000, 7'h7F, fs, 1'b1);
  endtask

  task automatic main_drive(input string tag, input int d, input logic [27:0] pat);
    logic [27:0] p;
    logic [3:0]  s;
    p = pat;
    s = 4'b0001 << d;
    tick();
    chk_main(tag, s, p[7*d +: 7], 1'b0, 1'b1);
  endtask

  // One full 24-clock frame; optionally change digit_seg early in digit 1's dwell
  task automatic frame(input string tag, input logic [27:0] pat, input bit change,
                       input logic [27:0] new_pat);
    for (int d = 0; d < 4; d++) begin
      main_blank(tag, d == 0);
      main_blank(tag, 1'b0);
      for (int k = 0; k < 4; k++) begin
        main_drive(tag, d, pat);
        if (change && d == 1 && k == 0) m_if.digit_seg = new_pat;
      end
    end
  endtask

  task automatic one_period(input string tag, input int bright);
    logic lit;
    tick();
    chk({tag, ".fs"},  32'(o_if.frame_start), 32'd1);
    chk({tag, ".sel"}, 32'(o_if.sel),         32'd0);
    tick();
    chk({tag, ".fs"},  32'(o_if.frame_start), 32'd0);
    chk({tag, ".seg"}, 32'(o_if.seg_out),     32'h7F);
    for (int k = 0; k < 32; k++) begin
`ifdef SEG_SCAN_DIM_EN
      lit = ((k % 16) <= bright);
`else
      lit = (bright >= 0);
`endif
      tick();
      chk({tag, ".sel"}, 32'(o_if.sel),     32'd1);
      chk({tag, ".seg"}, 32'(o_if.seg_out), lit ? 32'(PONE) : 32'h7F);
      chk({tag, ".fs"},  32'(o_if.frame_start), 32'd0);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    reset          = 1'b1;
    m_if.enable    = 1'b1;
    m_if.digit_seg = P1;
    o_if.enable    = 1'b0;
    o_if.digit_seg = PONE;
`ifdef SEG_SCAN_DIM_EN
    m_if.brightness = 4'd15;
    o_if.brightness = 4'd3;
`endif

    // Reset held with enable high: bus stays dark and idle
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_main("reset_hold", 4'b0000, 7'h7F, 1'b0, 1'b0);
      chk("one_reset.busy", 32'(o_if.busy), 32'd0);
    end

    // Normal scanning, then a mid-frame pattern change that must wait a frame
    reset = 1'b0;
    frame("frame1", P1, 1'b0, P1);
    frame("frame2", P1, 1'b1, P2);
    frame("frame3", P2, 1'b0, P2);

    // enable dropped during digit 2 drive
    for (int d = 0; d < 2; d++) begin
      main_blank("pre_dis", d == 0);
      main_blank("pre_dis", 1'b0);
      for (int k = 0; k < 4; k++) main_drive("pre_dis", d, P2);
    end
    main_blank("pre_dis", 1'b0);
    main_blank("pre_dis", 1'b0);
    main_drive("pre_dis", 2, P2);
    m_if.enable = 1'b0;
    tick();
    chk_main("disabled", 4'b0000, 7'h7F, 1'b0, 1'b0);
    tick();
    chk_main("disabled2", 4'b0000, 7'h7F, 1'b0, 1'b0);
    m_if.enable = 1'b1;
    frame("reenable", P2, 1'b0, P2);

    // reset asserted mid-drive with enable still high
    main_blank("pre_rst", 1'b1);
    main_blank("pre_rst", 1'b0);
    main_drive("pre_rst", 0, P2);
    main_drive("pre_rst", 0, P2);
    reset = 1'b1;
    m_if.digit_seg = P1;
    tick();
    chk_main("mid_reset", 4'b0000, 7'h7F, 1'b0, 1'b0);
    tick();
    chk_main("mid_reset2", 4'b0000, 7'h7F, 1'b0, 1'b0);
    reset = 1'b0;
    frame("post_reset", P1, 1'b0, P1);

    // Single digit, 32-clock dwell: frame_start every 34 clocks
    o_if.enable = 1'b1;
    one_period("one_b3", 3);
`ifdef SEG_SCAN_DIM_EN
    o_if.brightness = 4'd15;
`endif
    one_period("one_b15", 15);
    o_if.enable = 1'b0;
    tick();
    chk("one_off.busy", 32'(o_if.busy),    32'd0);
    chk("one_off.seg",  32'(o_if.seg_out), 32'h7F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
